sd_modulator: RTL and testbench
===============================

// Module: sd_modulator
// PURPOSE
//  Digital delta-sigma modulator: turns signed PCM samples into a 1-bit direct-stream (DSD) bitstream
//  clocked by sd_clk_in. It is the transmit-side counterpart of the FILT sinc decimator and drives a
//  filter's sd_dsd_in for loopback/self-test or an external 1-bit DAC. A 1-entry sample buffer with
//  valid/ready handshake is reloaded once per frame of (reg_moddec+1) bit clocks, the same OSR as FILT.
// PARAMETERS
//  DW     16  input sample width, signed two's complement; full scale FS = 2^(DW-1)
//  ACC_W  24  integrator width, signed; ACC_W >= DW+4
// PORTS
//  SYSRSTn       in   1      reset, asynchronous, active-low
//  sd_clk_in     in   1      clock; one output bit per rising edge
//  mod_en        in   1      modulator enable
//  mod_order     in   1      0: 1st order, 1: 2nd order
//  reg_moddec    in   8      frame length - 1 (oversampling ratio - 1)
//  sample_in     in   DW     PCM sample, signed
//  sample_valid  in   1      sample_in valid
//  sample_ready  out  1      buffer can accept a sample (= !hold_full)
//  sample_req    out  1      1-cycle pulse at each frame boundary (active sample reloaded)
//  underrun      out  1      sticky: frame boundary with no sample available
//  overload      out  1      sticky: any integrator saturated
//  flag_clr      in   1      clears underrun and overload (set has priority if same cycle)
//  sd_dsd_out    out  1      modulated bitstream, registered
// BEHAVIOUR
//  Reset: cnt=0, hold=0, hold_full=0, active=0, i1=i2=0, sd_dsd_out=0, sample_ready=1, sample_req=0,
//   underrun=0, overload=0. Async reset mid-frame aborts frame; buffered sample discarded.
//  Handshake: accept on edge when sample_valid && sample_ready -> hold<=sample_in, hold_full<=1.
//   Accepted regardless of mod_en. sample_ready is combinational !hold_full.
//  Frame counter (mod_en=1): boundary when cnt >= reg_moddec -> cnt<=0 else cnt+1 (>= so a reduced
//   reg_moddec never waits for 8-bit wrap). reg_moddec=0: boundary every clock.
//  At boundary (registered sample_req=1 same edge):
//   hold_full=1 -> active<=hold, hold_full<=0 (buffer frees; new accept possible next edge).
//   hold_full=0 && sample_valid -> bypass: active<=sample_in, hold untouched, no underrun.
//   neither -> active holds previous value, underrun<=1.
//  Loop (mod_en=1, every edge): fb = sd_dsd_out ? +FS : -FS (sign-extended to ACC_W).
//   x = active at edge time (new active used from next edge).
//   i1n = sat(i1 + x - fb); i1 <= i1n.
//   order 2: i2n = sat(i2 + i1n - 2*fb); i2 <= i2n; else i2 <= 0.
//   sd_dsd_out <= ~(order2 ? i2n : i1n)[ACC_W-1]  (1 when value >= 0).
//   sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; any clamp sets overload.
//  Stability: order 1 stable for |x| < FS; order 2 specified for |x| <= 0.7*FS.
//  mod_en=0: i1,i2,cnt cleared synchronously, sample_req=0, sd_dsd_out toggles every clock
//   (zero-mean idle), active retained. mod_en rise: first boundary after reg_moddec+1 clocks.
//  mod_order change mid-stream: takes effect next edge; no flush required.
//  Mean density: ones fraction -> (x/FS+1)/2; FILT output of loopback tracks x with sign/scale of FS.
// STRUCTURE
//  Package sd_pkg: FS/ACC sizing localparams, ORDER_1/ORDER_2 constants, sat helper function.
//  Sub-module sd_mod_integ: saturating signed accumulator (inputs: add operand, clr, en; outputs:
//   next value, sat flag); instantiated twice. Rest (counter, buffer, flags) in top.
// TESTING
//  1 order2, x=0, reg_moddec=63, 4096 clks -> ones count 2048 +/-8; no underrun/overload.
//  2 order1, x=+FS/2 (16384), 4096 clks -> ones 3072 +/-8; x=-FS/2 -> ones 1024 +/-8.
//  3 handshake: samples A,B,C written while hold_full -> ready=0 blocks B until sample_req; active
//    sequence A,B,C on successive frames; stop feeding -> underrun=1 at next boundary, active=C.
//  4 bypass: hold empty, valid asserted exactly at boundary cycle -> active=sample_in, underrun=0.
//  5 order2, x=FS-1 constant -> overload=1 within 2000 clks; flag_clr with no new clamp -> 0.
//  6 reset asserted mid-frame (cnt=30) with hold_full=1 -> all outputs at reset values; loopback
//    into FILT (sinc3, dec 64) with x=8192 -> settled FILT output constant +/-1 LSB over 16 frames.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared sizing, order encodings and the saturation helper for the delta-sigma modulator.
package sd_pkg;

  localparam int unsigned SD_DW    = 16;
  localparam int unsigned SD_ACC_W = 24;
  localparam int          SD_FS    = 1 << (SD_DW - 1);

  localparam logic ORDER_1 = 1'b0;
  localparam logic ORDER_2 = 1'b1;

  // Clamp v to the signed range of a w-bit integrator; returns 1 when a clamp occurred.
  function automatic logic sat_clamp(input  logic signed [63:0] v,
                                     input  int unsigned        w,
                                     output logic signed [63:0] r);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) begin
      r = hi;
      return 1'b1;
    end else if (v < lo) begin
      r = lo;
      return 1'b1;
    end
    r = v;
    return 1'b0;
  endfunction

endpackage

// File: rtl/sd_modulator_if.sv
// Sample handshake between a PCM source (master) and the modulator (slave).
interface sd_modulator_if
  import sd_pkg::*;
#(
  parameter int unsigned DW = SD_DW
);
  logic signed [DW-1:0] sample_in;
  logic                 sample_valid;
  logic                 sample_ready;
  logic                 sample_req;

  modport master (
    output sample_in,
    output sample_valid,
    input  sample_ready,
    input  sample_req
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output sample_ready,
    output sample_req
  );
endinterface

// File: rtl/sd_mod_integ.sv
// Saturating signed accumulator: exposes the clamped next value so later stages can chain on it
// within the same clock.
module sd_mod_integ
  import sd_pkg::*;
#(
  parameter int unsigned ACC_W = SD_ACC_W,
  parameter int unsigned OW    = SD_ACC_W + 2
) (
  input  logic                    sd_clk_in,
  input  logic                    SYSRSTn,
  input  logic                    en,
  input  logic                    clr,
  input  logic signed [OW-1:0]    add,
  output logic signed [ACC_W-1:0] nxt,
  output logic                    sat
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [63:0]      sum;
  logic signed [63:0]      clamped;

  // Wide sum, then clamp back into the integrator range.
  always_comb begin
    sum     = 64'(acc_q) + 64'(add);
    clamped = '0;
    sat     = sat_clamp(sum, ACC_W, clamped);
    nxt     = clamped[ACC_W-1:0];
  end

  // Integrator state; clear wins over enable.
  always_ff @(posedge sd_clk_in or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= nxt;
    end
  end

endmodule

// File: rtl/sd_modulator.sv
// Digital delta-sigma modulator: signed PCM in, 1-bit DSD stream out, one sample per frame of
// reg_moddec+1 bit clocks through a single-entry buffer.
module sd_modulator
  import sd_pkg::*;
#(
  parameter int unsigned DW    = SD_DW,
  parameter int unsigned ACC_W = SD_ACC_W
) (
  input  logic                 SYSRSTn,
  input  logic                 sd_clk_in,
  input  logic                 mod_en,
  input  logic                 mod_order,
  input  logic [7:0]           reg_moddec,
  input  logic                 flag_clr,
  output logic                 underrun,
  output logic                 overload,
  output logic                 sd_dsd_out,
  sd_modulator_if.slave        smp
);

  localparam int unsigned OW = ACC_W + 2;
  localparam logic signed [OW-1:0] FS_V = {{(OW - DW){1'b0}}, 1'b1, {(DW - 1){1'b0}}};

  logic [7:0]           cnt_q, cnt_d;
  logic signed [DW-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic signed [DW-1:0] active_q, active_d;
  logic                 sample_req_q, sample_req_d;
  logic                 underrun_q, underrun_d;
  logic                 overload_q, overload_d;
  logic                 sd_dsd_q, sd_dsd_d;

  logic                    boundary;
  logic                    order2;
  logic signed [OW-1:0]    x_ext;
  logic signed [OW-1:0]    fb_ext;
  logic signed [OW-1:0]    add1;
  logic signed [OW-1:0]    add2;
  logic signed [ACC_W-1:0] i1n;
  logic signed [ACC_W-1:0] i2n;
  logic                    sat1;
  logic                    sat2;

  // >= so that shrinking reg_moddec mid-frame ends the frame right away.
  assign boundary = mod_en && (cnt_q >= reg_moddec);
  assign order2   = (mod_order == ORDER_2);

  assign x_ext  = OW'(active_q);
  assign fb_ext = sd_dsd_q ? FS_V : -FS_V;
  assign add1   = x_ext - fb_ext;
  assign add2   = OW'(i1n) - (fb_ext <<< 1);

  sd_mod_integ #(
    .ACC_W (ACC_W),
    .OW    (OW)
  ) u_integ1 (
    .sd_clk_in (sd_clk_in),
    .SYSRSTn   (SYSRSTn),
    .en        (mod_en),
    .clr       (!mod_en),
    .add       (add1),
    .nxt       (i1n),
    .sat       (sat1)
  );

  sd_mod_integ #(
    .ACC_W (ACC_W),
    .OW    (OW)
  ) u_integ2 (
    .sd_clk_in (sd_clk_in),
    .SYSRSTn   (SYSRSTn),
    .en        (mod_en),
    .clr       (!mod_en || (mod_order == ORDER_1)),
    .add       (add2),
    .nxt       (i2n),
    .sat       (sat2)
  );

  assign smp.sample_ready = !hold_full_q;
  assign smp.sample_req   = sample_req_q;
  assign underrun         = underrun_q;
  assign overload         = overload_q;
  assign sd_dsd_out       = sd_dsd_q;

  // Frame counter, sample buffer, sticky flags and output bit.
  always_comb begin
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    active_d     = active_q;
    sample_req_d = boundary;
    underrun_d   = underrun_q && !flag_clr;
    overload_d   = overload_q && !flag_clr;
    sd_dsd_d     = ~sd_dsd_q;

    if (mod_en) begin
      cnt_d    = boundary ? 8'd0 : cnt_q + 8'd1;
      sd_dsd_d = ~(order2 ? i2n[ACC_W-1] : i1n[ACC_W-1]);
      if (sat1 || (order2 && sat2)) begin
        overload_d = 1'b1;
      end
    end else begin
      cnt_d = 8'd0;
    end

    if (boundary) begin
      if (hold_full_q) begin
        active_d    = hold_q;
        hold_full_d = 1'b0;
      end else if (smp.sample_valid) begin
        // Empty buffer but a sample is on the bus: feed it straight through.
        active_d = smp.sample_in;
      end else begin
        underrun_d = 1'b1;
      end
    end else if (smp.sample_valid && !hold_full_q) begin
      hold_d      = smp.sample_in;
      hold_full_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge sd_clk_in or negedge SYSRSTn) begin
    if (!SYSRSTn) begin
      cnt_q        <= 8'd0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      active_q     <= '0;
      sample_req_q <= 1'b0;
      underrun_q   <= 1'b0;
      overload_q   <= 1'b0;
      sd_dsd_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      active_q     <= active_d;
      sample_req_q <= sample_req_d;
      underrun_q   <= underrun_d;
      overload_q   <= overload_d;
      sd_dsd_q     <= sd_dsd_d;
    end
  end

endmodule

// File: tb/tb_sd_modulator.sv
// Self-checking bench for sd_modulator: cycle-level arithmetic model plus directed density,
// handshake, bypass, overload and reset scenarios, then randomized traffic.
module tb_sd_modulator;

  localparam int  DW   = 16;
  localparam longint FS   = 32768;
  localparam longint AMAX = (64'sd1 <<< 23) - 1;
  localparam longint AMIN = -(64'sd1 <<< 23);

  logic       sd_clk_in  = 1'b0;
  logic       SYSRSTn    = 1'b0;
  logic       mod_en     = 1'b0;
  logic       mod_order  = 1'b0;
  logic [7:0] reg_moddec = 8'd0;
  logic       flag_clr   = 1'b0;
  logic       underrun;
  logic       overload;
  logic       sd_dsd_out;

  sd_modulator_if #(.DW(DW)) smp_if ();

  sd_modulator #(
    .DW    (DW),
    .ACC_W (24)
  ) dut (
    .SYSRSTn    (SYSRSTn),
    .sd_clk_in  (sd_clk_in),
    .mod_en     (mod_en),
    .mod_order  (mod_order),
    .reg_moddec (reg_moddec),
    .flag_clr   (flag_clr),
    .underrun   (underrun),
    .overload   (overload),
    .sd_dsd_out (sd_dsd_out),
    .smp        (smp_if)
  );

  always #5 sd_clk_in = ~sd_clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  longint m_i1, m_i2, m_active, m_hold;
  bit     m_full, m_dsd, m_req, m_ur, m_ov;
  int     m_cnt;

  function automatic longint clampv(input longint v, output bit s);
    s = 1'b0;
    if (v > AMAX) begin s = 1'b1; return AMAX; end
    if (v < AMIN) begin s = 1'b1; return AMIN; end
    return v;
  endfunction

  task automatic model_reset();
    m_i1 = 0; m_i2 = 0; m_active = 0; m_hold = 0;
    m_full = 0; m_dsd = 0; m_req = 0; m_ur = 0; m_ov = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    longint fb, i1n, i2n, s;
    bit bnd, s1, s2, ov_set, ur_set, nd;
    if (!SYSRSTn) return;
    s      = longint'(smp_if.sample_in);
    bnd    = mod_en && (m_cnt >= int'(reg_moddec));
    ov_set = 0;
    ur_set = 0;
    if (mod_en) begin
      fb  = m_dsd ? FS : -FS;
      i1n = clampv(m_i1 + m_active - fb, s1);
      ov_set = s1;
      if (mod_order) begin
        i2n = clampv(m_i2 + i1n - 2 * fb, s2);
        ov_set = ov_set | s2;
        nd = (i2n >= 0);
      end else begin
        i2n = 0;
        nd = (i1n >= 0);
      end
      m_i1 = i1n;
      m_i2 = i2n;
    end else begin
      m_i1 = 0;
      m_i2 = 0;
      nd = !m_dsd;
    end
    if (bnd) begin
      if (m_full) begin
        m_active = m_hold;
        m_full   = 0;
      end else if (smp_if.sample_valid) begin
        m_active = s;
      end else begin
        ur_set = 1;
      end
    end else if (smp_if.sample_valid && !m_full) begin
      m_hold = s;
      m_full = 1;
    end
    m_ur  = ur_set || (m_ur && !flag_clr);
    m_ov  = ov_set || (m_ov && !flag_clr);
    m_req = bnd;
    m_cnt = mod_en ? (bnd ? 0 : m_cnt + 1) : 0;
    m_dsd = nd;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sd_clk_in);
      model_step();
    end
  end

  initial forever begin
    @(negedge SYSRSTn);
    model_reset();
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    logic [4:0] act, exp;
    @(negedge sd_clk_in);
    exp = {!m_full, m_req, m_ur, m_ov, m_dsd};
    act = {smp_if.sample_ready, smp_if.sample_req, underrun, overload, sd_dsd_out};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL cycle_model t=%0t: ready/req/underrun/overload/dsd got %b required %b",
                 $time, act, exp);
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input longint got, input longint lo,
                             input longint hi);
    n_cmp++;
    if (got < lo || got > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sd_clk_in);
    #2;
  endtask

  task automatic wait_cnt(input int target, input string name);
    for (int i = 0; i < 600; i++) begin
      if (m_cnt == target) return;
      tick(1);
    end
    check(name, m_cnt, target);
  endtask

  task automatic send(input int v, input string name);
    logic r;
    smp_if.sample_in    = 16'(v);
    smp_if.sample_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      @(negedge sd_clk_in);
      r = smp_if.sample_ready;
      tick(1);
      if (r) begin
        smp_if.sample_valid = 1'b0;
        return;
      end
    end
    smp_if.sample_valid = 1'b0;
    check(name, 0, 1);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    for (int i = 0; i < n; i++) begin
      tick(1);
      ones += int'(sd_dsd_out);
    end
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  ones;
    bit  d0;
    int  v;
    smp_if.sample_in    = '0;
    smp_if.sample_valid = 1'b0;

    // Reset values
    tick(3);
    check("rst_ready", smp_if.sample_ready, 1);
    check("rst_req", smp_if.sample_req, 0);
    check("rst_underrun", underrun, 0);
    check("rst_overload", overload, 0);
    check("rst_dsd", sd_dsd_out, 0);
    SYSRSTn = 1'b1;
    tick(1);

    // Order 2, zero input: half density
    mod_order = 1'b1; reg_moddec = 8'd63; mod_en = 1'b1;
    smp_if.sample_in = '0; smp_if.sample_valid = 1'b1;
    tick(256);
    count_ones(4096, ones);
    check_range("ord2_zero_ones", ones, 2040, 2056);
    check("ord2_zero_underrun", underrun, 0);
    check("ord2_zero_overload", overload, 0);

    // Order 1, +/- half scale
    mod_order = 1'b0; smp_if.sample_in = 16'sd16384;
    tick(256);
    count_ones(4096, ones);
    check_range("ord1_pos_half_ones", ones, 3064, 3080);
    smp_if.sample_in = -16'sd16384;
    tick(256);
    count_ones(4096, ones);
    check_range("ord1_neg_half_ones", ones, 1016, 1032);

    // Handshake: A fills buffer, B and C wait for frame boundaries, then starve
    smp_if.sample_valid = 1'b0; reg_moddec = 8'd7;
    tick(20);
    flag_clr = 1'b1; tick(1); flag_clr = 1'b0;
    wait_cnt(1, "hs_align");
    send(1000, "hs_send_a");
    check("hs_ready_after_a", smp_if.sample_ready, 0);
    send(-2000, "hs_send_b");
    send(3000, "hs_send_c");
    for (int i = 0; i < 40 && !underrun; i++) tick(1);
    check("hs_underrun_after_starve", underrun, 1);

    // Bypass: empty buffer, valid exactly on the boundary cycle
    wait_cnt(7, "bp_align");
    smp_if.sample_in = 16'sd4000; smp_if.sample_valid = 1'b1; flag_clr = 1'b1;
    tick(1);
    smp_if.sample_valid = 1'b0; flag_clr = 1'b0;
    check("bp_underrun", underrun, 0);
    check("bp_ready", smp_if.sample_ready, 1);
    check("bp_req", smp_if.sample_req, 1);

    // Overload: order 2 at near full scale, then clear while idle
    mod_order = 1'b1; reg_moddec = 8'd63;
    smp_if.sample_in = 16'sd32767; smp_if.sample_valid = 1'b1;
    for (int i = 0; i < 2000 && !overload; i++) tick(1);
    check("ovl_set", overload, 1);
    mod_en = 1'b0; smp_if.sample_valid = 1'b0;
    tick(2);
    flag_clr = 1'b1; tick(1); flag_clr = 1'b0;
    check("ovl_cleared", overload, 0);
    check("idle_req", smp_if.sample_req, 0);
    d0 = sd_dsd_out;
    tick(1);
    check("idle_toggle", sd_dsd_out, !d0);

    // Reset mid-frame with a buffered sample
    mod_en = 1'b1; mod_order = 1'b0; reg_moddec = 8'd63;
    wait_cnt(10, "rst_align_a");
    send(1234, "rst_send");
    check("rst_hold_full", smp_if.sample_ready, 0);
    wait_cnt(30, "rst_align_b");
    SYSRSTn = 1'b0;
    #1;
    check("mid_rst_ready", smp_if.sample_ready, 1);
    check("mid_rst_req", smp_if.sample_req, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_overload", overload, 0);
    check("mid_rst_dsd", sd_dsd_out, 0);
    tick(2);
    SYSRSTn = 1'b1;

    // Order 2 at x=8192: density 0.625
    mod_order = 1'b1; smp_if.sample_in = 16'sd8192; smp_if.sample_valid = 1'b1;
    tick(256);
    count_ones(4096, ones);
    check_range("ord2_quarter_ones", ones, 2552, 2568);

    // Randomized traffic
    for (int c = 0; c < 6000; c++) begin
      if (c % 400 == 0) begin
        reg_moddec = 8'($urandom_range(0, 12));
        mod_order  = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 199) == 0) mod_en = !mod_en;
      v = int'($urandom_range(0, 44000)) - 22000;
      smp_if.sample_in    = 16'(v);
      smp_if.sample_valid = ($urandom_range(0, 3) != 0);
      flag_clr = ($urandom_range(0, 49) == 0);
      if (c == 3000) begin
        SYSRSTn = 1'b0;
        #1;
        SYSRSTn = 1'b1;
      end
      tick(1);
    end
    smp_if.sample_valid = 1'b0;
    flag_clr = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
